uart_tx_phy: RTL and testbench
==============================

// Module: uart_tx_phy
// PURPOSE
//  Serial transmit end of the UART byte-stream interface that sram_uart_lite drives out on
//  tx_data/tx_valid/tx_ready. Accepts bytes by valid/ready handshake into a small FIFO and
//  shifts each one out on txd as an 8N1 frame (start, 8 data LSB first, stop) at CLK_DIV clk/bit.
//  Sits between the uart instance in cpu_top and the board TX pin, replacing the tx_ready=1 tie-off.
// PARAMETERS
//  CLK_DIV     868  clk cycles per serial bit (100 MHz / 115200); legal range >= 2
//  FIFO_DEPTH  4    byte FIFO entries; power of two, >= 2
// PORTS
//  clk         in   1                        system clock, all logic on rising edge
//  rst         in   1                        synchronous reset, active-high
//  tx_data     in   8                        byte to transmit
//  tx_valid    in   1                        tx_data valid
//  tx_ready    out  1                        FIFO can accept; push = tx_valid & tx_ready at edge
//  txd         out  1                        serial output, idle high, registered
//  busy        out  1                        FIFO non-empty or frame in progress
//  fifo_level  out  $clog2(FIFO_DEPTH)+1     bytes held in FIFO (excludes byte being shifted)
// BEHAVIOUR
//  Reset (rst high at edge): txd=1, state=IDLE, FIFO flushed (level=0), baud/bit counters=0;
//   busy=0. tx_ready=0 while rst high, =1 first cycle after rst low. Reset mid-frame aborts
//   frame: txd=1 at that edge, no residual bits or bytes afterwards.
//  tx_ready = !rst && (fifo_level != FIFO_DEPTH), derived from registered count only (no
//   combinational path from tx_valid). tx_data ignored whenever tx_ready=0.
//  FIFO: push at tail on handshake; pop head on IDLE->START or STOP->START transition.
//   Simultaneous push+pop: level unchanged, both take effect. Pointers wrap mod FIFO_DEPTH.
//   When full, a pop raises tx_ready the following cycle (no same-cycle pass-through).
//  FSM (all states hold CLK_DIV cycles, baud counter 0..CLK_DIV-1, advance on terminal count):
//   IDLE : txd=1; if level>0 -> pop head into shift reg, go START.
//   START: txd=0; -> DATA, bit_idx=0.
//   DATA : txd=shift[0]; on terminal count shift right; bit_idx 0..7; after bit 7 -> STOP.
//   STOP : txd=1; on terminal count: level>0 -> pop, go START (no idle gap); else -> IDLE.
//  Latency: byte accepted at edge N into empty idle block -> txd falls at edge N+1.
//  Frame = exactly 10*CLK_DIV cycles; back-to-back frames contiguous.
//  busy = (state!=IDLE) || (fifo_level!=0), registered-state derived.
//  Counters sized $clog2(CLK_DIV) and 3 bits; no overflow beyond CLK_DIV-1.
// TESTING (CLK_DIV=4, FIFO_DEPTH=4 unless stated)
//  1. After reset push 0x55 -> txd 0,1,0,1,0,1,0,1,0,1 each 4 cycles starting edge after push
//     (40 cycles), then txd=1, busy=0, fifo_level=0.
//  2. Push 0x00 then 0xFF on consecutive cycles -> second start bit begins the cycle after first
//     stop bit's 4th cycle; 80 cycles total, no extra idle high.
//  3. Hold tx_valid with 6 distinct bytes -> 5 accepted by edge 4 (b0 in shifter, level=4),
//     tx_ready=0; b5 accepted cycle after b0 frame ends; all 6 bytes emerge in order, unaltered.
//  4. Assert rst during DATA bit 3 of 0xA5 with 2 bytes queued -> txd=1 at that edge,
//     fifo_level=0, busy=0; no further low on txd until new push.
//  5. While full, change tx_data each cycle with tx_valid=1 -> only values present on
//     handshake cycles are transmitted; tx_ready never depends combinationally on tx_valid.
//  6. CLK_DIV=2, random 64-byte stream with random valid gaps -> scoreboard decodes txd exactly,
//     frame width 20 cycles, fifo_level never > 4.

Source files
------------

// File: rtl/uart_tx_phy_if.sv
// Byte-stream handshake between a UART byte source and the serial transmitter.
// The master drives tx_data/tx_valid. The slave returns tx_ready.
interface uart_tx_phy_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_phy.sv
// UART transmit PHY.
// Bytes are accepted by valid/ready handshake into a small FIFO.
// Each byte is shifted out on txd as an 8N1 frame: a start bit, 8 data bits
// LSB first, and a stop bit. Every bit lasts CLK_DIV clocks.
// When another byte is queued, it follows the stop bit with no idle gap.
module uart_tx_phy #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_phy_if.slave                  tx_if,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [2:0]       BIT_LAST  = 3'd7;
  localparam logic [2:0]       BIT_ONE   = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_baud;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_txd;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_count;

  logic w_push;
  logic w_pop;
  logic w_not_empty;
  logic w_baud_tc;
  logic w_ready;

  // tx_ready is derived from the registered fill count only.
  // Nothing on tx_valid can loop back into tx_ready.
  assign w_ready     = !rst && (r_count != LVL_FULL);
  assign w_push      = tx_if.tx_valid && w_ready;
  assign w_not_empty = (r_count != '0);
  assign w_baud_tc   = (r_baud == BAUD_LAST);
  // A byte leaves the FIFO only when a frame is launched.
  // A frame is launched straight from idle, or back-to-back at the end of a stop bit.
  assign w_pop       = w_not_empty &&
                       ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_tc));

  assign tx_if.tx_ready = w_ready;
  assign txd            = r_txd;
  assign busy           = (r_state != ST_IDLE) || w_not_empty;
  assign fifo_level     = r_count;

  // FIFO storage. The entry is read later into the shift register, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_if.tx_data;
    end
  end

  // FIFO pointers and fill count. Push and pop may occur in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + LVL_ONE;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - LVL_ONE;
      end
    end
  end

  // Frame sequencer. txd is registered, and it is updated on the edge where a bit begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_baud    <= '0;
          r_bit_idx <= '0;
          r_txd     <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_txd   <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_baud_tc) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_txd     <= r_shift[0];
            r_state   <= ST_DATA;
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end
        ST_DATA: begin
          if (w_baud_tc) begin
            r_baud  <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit_idx == BIT_LAST) begin
              r_txd   <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + BIT_ONE;
              r_txd     <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end
        ST_STOP: begin
          if (w_baud_tc) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_txd   <= 1'b0;
              r_state <= ST_START;
            end else begin
              r_txd   <= 1'b1;
              r_state <= ST_IDLE;
            end
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end
        default: begin
          r_baud  <= '0;
          r_txd   <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_phy.sv
// Testbench for uart_tx_phy.
// dut_a runs with CLK_DIV=4 and dut_b with CLK_DIV=2.
// The stimulus pushes each accepted byte into a per-DUT expected queue.
// Independent monitors decode txd frames and compare them against those queues.
module tb_uart_tx_phy;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_txd, a_busy, b_txd, b_busy;
  logic [2:0] a_level, b_level;

  uart_tx_phy_if a_if ();
  uart_tx_phy_if b_if ();

  uart_tx_phy #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .tx_if(a_if), .txd(a_txd), .busy(a_busy), .fifo_level(a_level)
  );
  uart_tx_phy #(.CLK_DIV(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .tx_if(b_if), .txd(b_txd), .busy(b_busy), .fifo_level(b_level)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int max_b = 0;

  function automatic logic txd_of(input int w);
    return (w == 0) ? a_txd : b_txd;
  endfunction

  function automatic logic ready_of(input int w);
    return (w == 0) ? a_if.tx_ready : b_if.tx_ready;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  // Called at a negedge. Holds valid until a handshake, records the byte, then returns one negedge later.
  task automatic push(input int w, input logic [7:0] b);
    int n = 0;
    if (w == 0) begin a_if.tx_data = b; a_if.tx_valid = 1'b1; end
    else        begin b_if.tx_data = b; b_if.tx_valid = 1'b1; end
    while (ready_of(w) !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL push_timeout dut=%0d byte=%02h got=ready_low required=ready_high", w, b);
    end else if (w == 0) begin
      exp_a.push_back(b);
    end else begin
      exp_b.push_back(b);
    end
    @(negedge clk);
    if (w == 0) a_if.tx_valid = 1'b0; else b_if.tx_valid = 1'b0;
  endtask

  // Samples dut_a txd over nbits*4 negedges, starting at the current negedge.
  task automatic wave_check(input logic [19:0] exp_bits, input int nbits, input string name);
    int bad = 0;
    int first_bad = -1;
    logic got_bad = 1'b0;
    for (int i = 0; i < nbits * 4; i++) begin
      if (i > 0) @(negedge clk);
      if (a_txd !== exp_bits[i / 4]) begin
        if (bad == 0) begin first_bad = i; got_bad = a_txd; end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%b required=%b (%0d bad cycles)",
               name, first_bad, got_bad, exp_bits[first_bad / 4], bad);
    end
  endtask

  task automatic wait_idle(input int w, input string name);
    int n = 0;
    while (n < 3000 && ((w == 0) ? (exp_a.size() != 0 || a_busy) : (exp_b.size() != 0 || b_busy))) begin
      @(negedge clk);
      n++;
    end
    chk(name, (n < 3000), 1'b1);
  endtask

  // Frame decoder. It checks start/stop levels, and that each bit holds for div cycles.
  // A reset seen mid-frame abandons that frame.
  task automatic monitor_run(input int w, input int div);
    logic [7:0] data;
    logic       bitv;
    logic       ok;
    logic       aborted;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (rst || txd_of(w) !== 1'b0) continue;
      aborted = 1'b0;
      ok      = 1'b1;
      data    = '0;
      bitv    = 1'b0;
      for (int b = 0; b < 10 && !aborted; b++) begin
        for (int c = 0; c < div && !aborted; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (rst) aborted = 1'b1;
          else if (c == 0) bitv = txd_of(w);
          else if (txd_of(w) !== bitv) ok = 1'b0;
        end
        if (!aborted) begin
          if (b == 0 && bitv !== 1'b0) ok = 1'b0;
          if (b == 9 && bitv !== 1'b1) ok = 1'b0;
          if (b >= 1 && b <= 8) data[b - 1] = bitv;
        end
      end
      if (aborted) continue;
      checks++;
      if ((w == 0 && exp_a.size() == 0) || (w == 1 && exp_b.size() == 0)) begin
        failures++;
        $display("FAIL mon%0d_unexpected_frame got=%02h required=none", w, data);
      end else begin
        exp = (w == 0) ? exp_a.pop_front() : exp_b.pop_front();
        if (!ok || data !== exp) begin
          failures++;
          $display("FAIL mon%0d_frame got=%02h framing_ok=%b required=%02h framing_ok=1", w, data, ok, exp);
        end else begin
          $display("frame dut%0d byte=%02h", w, data);
        end
      end
    end
  endtask

  initial monitor_run(0, 4);
  initial monitor_run(1, 2);

  always @(negedge clk) begin
    if (!rst && int'(b_level) > max_b) max_b = int'(b_level);
  end

  initial begin
    logic [7:0] t3 [6];
    logic [7:0] good [3];
    logic r0, r1;
    int   n, k, cyc;

    t3   = '{8'h3C, 8'hC3, 8'h5A, 8'h96, 8'h0F, 8'hF0};
    good = '{8'h71, 8'h72, 8'h73};
    a_if.tx_valid = 1'b0; a_if.tx_data = '0;
    b_if.tx_valid = 1'b0; b_if.tx_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_txd", a_txd, 1'b1);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_level", a_level, 3'd0);
    chk("rst_ready", a_if.tx_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", a_if.tx_ready, 1'b1);

    // 1: single byte 0x55
    push(0, 8'h55);
    @(negedge clk);
    wave_check({10'b0, 1'b1, 8'h55, 1'b0}, 10, "t1_wave");
    @(negedge clk);
    chk("t1_txd_idle", a_txd, 1'b1);
    chk("t1_busy", a_busy, 1'b0);
    chk("t1_level", a_level, 3'd0);

    // 2: 0x00 then 0xFF back to back
    repeat (3) @(negedge clk);
    push(0, 8'h00);
    push(0, 8'hFF);
    wave_check({1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0}, 20, "t2_wave");
    @(negedge clk);
    chk("t2_txd_idle", a_txd, 1'b1);
    chk("t2_busy", a_busy, 1'b0);

    // 3: six bytes with valid held
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) push(0, t3[i]);
    chk("t3_level_full", a_level, 3'd4);
    chk("t3_ready_low", a_if.tx_ready, 1'b0);
    n = 0;
    while (!a_if.tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t3_ready_delay", n, 37);
    push(0, t3[5]);
    wait_idle(0, "t3_drain");

    // 4: reset during DATA bit 3 of 0xA5 with 2 bytes queued
    repeat (3) @(negedge clk);
    push(0, 8'hA5);
    push(0, 8'h11);
    push(0, 8'h22);
    repeat (16) @(negedge clk);
    chk("t4_pre_bit3", a_txd, 1'b0);
    chk("t4_pre_level", a_level, 3'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_txd", a_txd, 1'b1);
    chk("t4_level", a_level, 3'd0);
    chk("t4_busy", a_busy, 1'b0);
    chk("t4_ready_in_rst", a_if.tx_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_a.delete();
    @(negedge clk);
    chk("t4_ready_after", a_if.tx_ready, 1'b1);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (a_txd !== 1'b1 || a_busy !== 1'b0) n++;
      @(negedge clk);
    end
    chk("t4_quiet_cycles", n, 0);

    // 5: data churn while full
    for (int i = 0; i < 5; i++) push(0, 8'h31 + 8'(i));
    a_if.tx_data = 8'hEE;
    a_if.tx_valid = 1'b0;
    #1 r0 = a_if.tx_ready;
    a_if.tx_valid = 1'b1;
    #1 r1 = a_if.tx_ready;
    chk("t5_ready_valid0", r0, 1'b0);
    chk("t5_ready_valid1", r1, 1'b0);
    @(negedge clk);
    k = 0;
    cyc = 0;
    while (k < 3 && cyc < 400) begin
      a_if.tx_valid = 1'b1;
      if (a_if.tx_ready) begin
        a_if.tx_data = good[k];
        exp_a.push_back(good[k]);
        k++;
      end else begin
        a_if.tx_data = 8'hC0 + 8'(cyc);
      end
      @(negedge clk);
      cyc++;
    end
    a_if.tx_valid = 1'b0;
    chk("t5_accepted", k, 3);
    wait_idle(0, "t5_drain");

    // 6: CLK_DIV=2, 64 random bytes with random gaps
    for (int i = 0; i < 64; i++) begin
      push(1, 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle(1, "t6_drain");
    checks++;
    if (max_b > 4) begin
      failures++;
      $display("FAIL t6_max_level got=%0d required<=4", max_b);
    end

    repeat (5) @(negedge clk);
    chk("end_queue_a", exp_a.size(), 0);
    chk("end_queue_b", exp_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
